// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: frames bytes, assembles 3/4-byte packets, tracks clamped cursor, buttons and wheel.
// Latency: outputs and packet_valid register 1 clk after the final byte's stop-bit falling edge is seen.
// No backpressure: the PS/2 device sets the pace and every completed packet is applied at once.
module ps2_mouse_tracker #(
    parameter int MAX_X          = 639,
    parameter int MAX_Y          = 479,
    parameter int COORD_W        = 10,
    parameter int PACKET_BYTES   = 3,
    parameter int SPEED_SHIFT    = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic [COORD_W-1:0] mouseX,
    output logic [COORD_W-1:0] mouseY,
    output logic               mouseLeftButton,
    output logic               mouseRightButton,
    output logic               mouseMiddleButton,
    output logic [7:0]         wheel,
    output logic               packet_valid,
    output logic               frame_error
);
    localparam int         MAG_W    = COORD_W + 3;
    localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
    logic fall;

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [1:0]         idx_q, idx_d;
    // Header byte without its always-one sync bit: {yovf, xovf, ysign, xsign, mid, right, left}
    logic [6:0]         hdr_q, hdr_d;
    logic [7:0]         b1_q, b1_d, b2_q, b2_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]         btn_q, btn_d;
    logic [7:0]         wheel_q, wheel_d;
    logic               pv_q, pv_d, fe_q, fe_d;

    logic [7:0]         pkt_b2;
    logic [8:0]         dx_raw, dy_raw, dx_mag9, dy_mag9;
    logic [MAG_W-1:0]   dx_mag, dy_mag, x_ext, y_ext, x_sum, y_sum;
    logic [COORD_W-1:0] x_new, y_new;
    logic [8:0]         w_sum;
    logic [7:0]         w_new;

    // Two-flop synchronisers plus one history flop on ps2_clk for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign fall = clk_s3_q & ~clk_s2_q;

    // In a 3-byte packet the Y byte is the one completing right now; in a 4-byte packet it was stored.
    assign pkt_b2 = (PACKET_BYTES == 4) ? b2_q : shift_q;

    // Apply the packet deltas to the current cursor/wheel with saturation; magnitudes are widened so nothing wraps.
    always_comb begin
        dx_raw  = {hdr_q[3], b1_q};
        dy_raw  = {hdr_q[4], pkt_b2};
        dx_mag9 = hdr_q[5] ? 9'd0 : (dx_raw[8] ? (~dx_raw + 9'd1) : dx_raw);
        dy_mag9 = hdr_q[6] ? 9'd0 : (dy_raw[8] ? (~dy_raw + 9'd1) : dy_raw);
        dx_mag  = MAG_W'(dx_mag9) << SPEED_SHIFT;
        dy_mag  = MAG_W'(dy_mag9) << SPEED_SHIFT;
        x_ext   = MAG_W'(x_q);
        y_ext   = MAG_W'(y_q);
        x_sum   = x_ext + dx_mag;
        y_sum   = y_ext + dy_mag;
        x_new   = x_q;
        y_new   = y_q;
        // Negative dx moves left
        if (dx_raw[8]) begin
            x_new = (dx_mag >= x_ext) ? '0 : COORD_W'(x_ext - dx_mag);
        end else begin
            x_new = (x_sum > MAG_W'(MAX_X)) ? COORD_W'(MAX_X) : COORD_W'(x_sum);
        end
        // Mouse +Y is up but screen +Y is down, so positive dy subtracts
        if (!dy_raw[8]) begin
            y_new = (dy_mag >= y_ext) ? '0 : COORD_W'(y_ext - dy_mag);
        end else begin
            y_new = (y_sum > MAG_W'(MAX_Y)) ? COORD_W'(MAX_Y) : COORD_W'(y_sum);
        end
        w_sum = {wheel_q[7], wheel_q} + {{5{shift_q[3]}}, shift_q[3:0]};
        w_new = wheel_q;
        if (PACKET_BYTES == 4) begin
            if (w_sum[8:7] == 2'b01)      w_new = 8'h7F;
            else if (w_sum[8:7] == 2'b10) w_new = 8'h80;
            else                          w_new = w_sum[7:0];
        end
    end

    // Frame FSM, packet assembly, timeout and output update decisions.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        to_cnt_d  = to_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        btn_d     = btn_q;
        wheel_d   = wheel_q;
        pv_d      = 1'b0;
        fe_d      = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s2_q || !(^{shift_q, par_q})) begin
                        fe_d  = 1'b1;
                        idx_d = 2'd0;
                    end else if (idx_q == 2'd0 && !shift_q[3]) begin
                        // Header without its sync bit: drop and keep hunting for a header
                        fe_d = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        x_d     = x_new;
                        y_d     = y_new;
                        btn_d   = hdr_q[2:0];
                        wheel_d = w_new;
                        pv_d    = 1'b1;
                        idx_d   = 2'd0;
                    end else begin
                        if (idx_q == 2'd0) hdr_d = {shift_q[7:4], shift_q[2:0]};
                        if (idx_q == 2'd1) b1_d = shift_q;
                        if (idx_q == 2'd2) b2_d = shift_q;
                        idx_d = idx_q + 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE || idx_q != 2'd0) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_d = '0;
                state_d  = S_IDLE;
                idx_d    = 2'd0;
                fe_d     = (state_q != S_IDLE);
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            idx_q     <= 2'd0;
            hdr_q     <= 7'd0;
            b1_q      <= 8'd0;
            b2_q      <= 8'd0;
            to_cnt_q  <= '0;
            x_q       <= COORD_W'(MAX_X / 2);
            y_q       <= COORD_W'(MAX_Y / 2);
            btn_q     <= 3'd0;
            wheel_q   <= 8'd0;
            pv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            to_cnt_q  <= to_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            btn_q     <= btn_d;
            wheel_q   <= wheel_d;
            pv_q      <= pv_d;
            fe_q      <= fe_d;
        end
    end

    assign mouseX            = x_q;
    assign mouseY            = y_q;
    assign mouseLeftButton   = btn_q[0];
    assign mouseRightButton  = btn_q[1];
    assign mouseMiddleButton = btn_q[2];
    assign wheel             = wheel_q;
    assign packet_valid      = pv_q;
    assign frame_error       = fe_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for two tracker instances: standard 3-byte packets and 4-byte wheel packets with speed shift.
// A high-level model pushes the expected event per byte; a monitor pops on packet_valid/frame_error.
// PS/2 lines are driven bit by bit with a slow clock relative to clk.
module tb_ps2_mouse_tracker;
    localparam int TO = 1500;
    localparam int H  = 5;

    typedef struct {
        int err;
        int x;
        int y;
        int btn;
        int whl;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      pc, pd;
    logic [1:0][9:0] mx, my;
    logic [1:0]      lb, rb, mb, pv, fe;
    logic [1:0][7:0] wh;

    int nchk = 0;
    int nfail = 0;

    exp_t q0[$];
    exp_t q1[$];

    int       m_x[2], m_y[2], m_btn[2], m_whl[2], m_idx[2];
    bit [7:0] m_buf[2][4];
    int       nbytes[2] = '{3, 4};
    int       shamt[2]  = '{0, 1};

    always #5 clk = ~clk;

    ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) u0 (
        .clk(clk), .rst(rst), .ps2_clk(pc[0]), .ps2_data(pd[0]),
        .mouseX(mx[0]), .mouseY(my[0]), .mouseLeftButton(lb[0]), .mouseRightButton(rb[0]),
        .mouseMiddleButton(mb[0]), .wheel(wh[0]), .packet_valid(pv[0]), .frame_error(fe[0])
    );

    ps2_mouse_tracker #(.PACKET_BYTES(4), .SPEED_SHIFT(1), .TIMEOUT_CYCLES(TO)) u1 (
        .clk(clk), .rst(rst), .ps2_clk(pc[1]), .ps2_data(pd[1]),
        .mouseX(mx[1]), .mouseY(my[1]), .mouseLeftButton(lb[1]), .mouseRightButton(rb[1]),
        .mouseMiddleButton(mb[1]), .wheel(wh[1]), .packet_valid(pv[1]), .frame_error(fe[1])
    );

    task automatic chk(string nm, int act, int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_x[u] = 319; m_y[u] = 239; m_btn[u] = 0; m_whl[u] = 0; m_idx[u] = 0;
        end
    endtask

    task automatic push_exp(int u, int err);
        exp_t e;
        e.err = err; e.x = m_x[u]; e.y = m_y[u]; e.btn = m_btn[u]; e.whl = m_whl[u];
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Reference: what the receiver should report after one byte arrives (c: 0 good, 1 bad parity, 2 bad stop).
    task automatic model_byte(int u, bit [7:0] b, int c);
        bit [7:0] h;
        int dx, dy, dz, sc;
        if (c != 0) begin
            m_idx[u] = 0;
            push_exp(u, 1);
        end else if (m_idx[u] == 0 && !b[3]) begin
            push_exp(u, 1);
        end else begin
            m_buf[u][m_idx[u]] = b;
            m_idx[u]++;
            if (m_idx[u] == nbytes[u]) begin
                m_idx[u] = 0;
                h  = m_buf[u][0];
                sc = 1 << shamt[u];
                dx = h[4] ? int'(m_buf[u][1]) - 256 : int'(m_buf[u][1]);
                dy = h[5] ? int'(m_buf[u][2]) - 256 : int'(m_buf[u][2]);
                if (h[6]) dx = 0;
                if (h[7]) dy = 0;
                m_x[u]   = clamp(m_x[u] + dx * sc, 0, 639);
                m_y[u]   = clamp(m_y[u] - dy * sc, 0, 479);
                m_btn[u] = int'(h[2:0]);
                if (nbytes[u] == 4) begin
                    dz = int'(m_buf[u][3][3:0]);
                    if (dz > 7) dz = dz - 16;
                    m_whl[u] = clamp(m_whl[u] + dz, -128, 127);
                end
                push_exp(u, 0);
            end
        end
    endtask

    task automatic drive_bits(int u, bit [10:0] fr, int n);
        for (int i = 0; i < n; i++) begin
            pd[u] = fr[i];
            cyc(H);
            pc[u] = 1'b0;
            cyc(H);
            pc[u] = 1'b1;
        end
        pd[u] = 1'b1;
        cyc(2 * H);
    endtask

    task automatic send_byte(int u, bit [7:0] b, int c);
        bit [10:0] fr;
        bit        par, stp;
        model_byte(u, b, c);
        par = (~^b) ^ (c == 1);
        stp = (c != 2);
        fr  = {stp, par, b, 1'b0};
        drive_bits(u, fr, 11);
    endtask

    task automatic send_pkt(int u, bit [7:0] b0, bit [7:0] b1, bit [7:0] b2, bit [7:0] b3);
        send_byte(u, b0, 0);
        send_byte(u, b1, 0);
        send_byte(u, b2, 0);
        if (nbytes[u] == 4) send_byte(u, b3, 0);
    endtask

    task automatic check_reset_state(int u);
        @(negedge clk);
        chk($sformatf("u%0d_rst_x", u), int'(mx[u]), 319);
        chk($sformatf("u%0d_rst_y", u), int'(my[u]), 239);
        chk($sformatf("u%0d_rst_btn", u), int'({mb[u], rb[u], lb[u]}), 0);
        chk($sformatf("u%0d_rst_wheel", u), int'(wh[u]), 0);
        chk($sformatf("u%0d_rst_pulses", u), int'({pv[u], fe[u]}), 0);
    endtask

    // Monitor: every output pulse must match the oldest expectation for that instance.
    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (pv[u] || fe[u]) begin
                    exp_t e;
                    int   got;
                    got = 0;
                    if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                    if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                    chk($sformatf("u%0d_exclusive_pulse", u), int'(pv[u] & fe[u]), 0);
                    chk($sformatf("u%0d_event_expected", u), got, 1);
                    if (got == 1) begin
                        chk($sformatf("u%0d_kind_frame_error", u), int'(fe[u]), e.err);
                        chk($sformatf("u%0d_mouseX", u), int'(mx[u]), e.x);
                        chk($sformatf("u%0d_mouseY", u), int'(my[u]), e.y);
                        chk($sformatf("u%0d_buttons", u), int'({mb[u], rb[u], lb[u]}), e.btn);
                        chk($sformatf("u%0d_wheel", u), int'($signed(wh[u])), e.whl);
                    end
                end
            end
        end
    end

    initial begin
        bit [7:0] b [4];
        rst = 1'b1;
        pc  = 2'b11;
        pd  = 2'b11;
        model_reset();
        cyc(5);
        rst = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        // Standard instance: basic move, buttons, clamping on both edges
        send_pkt(0, 8'h08, 8'h05, 8'h03, 8'h00);
        send_pkt(0, 8'h19, 8'h00, 8'h00, 8'h00);
        send_pkt(0, 8'h0A, 8'h00, 8'h00, 8'h00);
        send_pkt(0, 8'h18, 8'h00, 8'h00, 8'h00);
        send_pkt(0, 8'h18, 8'hC1, 8'h00, 8'h00);
        send_pkt(0, 8'h18, 8'hF6, 8'h00, 8'h00);
        send_pkt(0, 8'h08, 8'hFF, 8'h00, 8'h00);
        send_pkt(0, 8'h08, 8'hFF, 8'h00, 8'h00);
        send_pkt(0, 8'h08, 8'h7D, 8'h00, 8'h00);
        send_pkt(0, 8'h08, 8'h64, 8'h00, 8'h00);
        send_pkt(0, 8'h28, 8'h00, 8'h38, 8'h00);
        send_pkt(0, 8'h28, 8'h00, 8'h38, 8'h00);
        send_pkt(0, 8'h08, 8'h00, 8'h7F, 8'h00);
        send_pkt(0, 8'h08, 8'h00, 8'h7F, 8'h00);

        // Parity and stop-bit errors, then recovery
        send_byte(0, 8'h08, 0);
        send_byte(0, 8'h01, 1);
        send_pkt(0, 8'h08, 8'h01, 8'h00, 8'h00);
        send_byte(0, 8'h08, 0);
        send_byte(0, 8'h00, 2);
        send_pkt(0, 8'h08, 8'h02, 8'h00, 8'h00);

        // Partial packet abandoned by idle timeout, then a fresh packet
        send_byte(0, 8'h08, 0);
        send_byte(0, 8'h05, 0);
        cyc(TO + 100);
        m_idx[0] = 0;
        send_pkt(0, 8'h08, 8'h02, 8'h00, 8'h00);

        // Header without sync bit is dropped
        send_byte(0, 8'h00, 0);
        send_pkt(0, 8'h08, 8'h00, 8'h01, 8'h00);

        // Mid-frame timeout: start bit plus a few data bits, then silence
        push_exp(0, 1);
        m_idx[0] = 0;
        drive_bits(0, 11'b000_0000_0000, 5);
        cyc(TO + 100);
        send_pkt(0, 8'h08, 8'h03, 8'h00, 8'h00);

        // Reset in the middle of a packet and a frame discards everything silently
        send_byte(0, 8'h08, 0);
        drive_bits(0, 11'b000_0000_0000, 4);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        model_reset();
        check_reset_state(0);
        send_pkt(0, 8'h08, 8'h05, 8'h03, 8'h00);

        // Randomised traffic on the standard instance
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 3; k++) begin
                b[k] = 8'($urandom);
            end
            if ($urandom_range(0, 9) != 0) b[0][3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b[0][7:6] = 2'b00;
            for (int k = 0; k < 3; k++) begin
                send_byte(0, b[k], ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
        end

        // Wheel instance: shifted move, wheel, overflow bit, wheel saturation low
        send_pkt(1, 8'h08, 8'h03, 8'h00, 8'h0F);
        send_pkt(1, 8'h48, 8'h7F, 8'h00, 8'h00);
        for (int n = 0; n < 17; n++) send_pkt(1, 8'h08, 8'h00, 8'h00, 8'h08);
        send_pkt(1, 8'h08, 8'h00, 8'h00, 8'h07);
        send_byte(1, 8'h08, 0);
        send_byte(1, 8'h01, 0);
        send_byte(1, 8'h00, 0);
        send_byte(1, 8'h07, 1);
        send_pkt(1, 8'h98, 8'h80, 8'h80, 8'h01);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++) begin
                b[k] = 8'($urandom);
            end
            if ($urandom_range(0, 9) != 0) b[0][3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b[0][7:6] = 2'b00;
            for (int k = 0; k < 4; k++) begin
                send_byte(1, b[k], ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
        end

        cyc(200);
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
